// File: rtl/bram_write_sa_if.sv
// ---------------------------------------------------------------------------
// bram_write_sa_if
// Bundles the result-beat stream and the BRAM_CTRLW write port of
// bram_write_sa into one interface.
//   Stream : in_valid, in_ready, in_addr[12:0], in_data[31:0]
//   BRAM   : clka, rsta, ena, addra[31:0], dina[31:0], wea[3:0], douta[31:0]
// Modports:
//   master - the writer block: consumes the stream, masters the BRAM port.
//   slave  - the environment: produces the stream, sits behind the BRAM port.
// ---------------------------------------------------------------------------
interface bram_write_sa_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_addr;
    logic [31:0] in_data;
    logic        clka;
    logic        rsta;
    logic        ena;
    logic [31:0] addra;
    logic [31:0] dina;
    logic [3:0]  wea;
    logic [31:0] douta;

    modport master (
        input  in_valid, in_addr, in_data, douta,
        output in_ready, clka, rsta, ena, addra, dina, wea
    );

    modport slave (
        output in_valid, in_addr, in_data, douta,
        input  in_ready, clka, rsta, ena, addra, dina, wea
    );
endinterface

// File: rtl/bram_write_sa.sv
// ---------------------------------------------------------------------------
// bram_write_sa
// Writes a frame of systolic-array result words into a result BRAM through a
// BRAM_CTRL-style master port. Each accepted beat becomes one BRAM write on
// the following cycle; beats whose address is outside the BRAM are accepted
// and dropped. A frame ends after NUM_WORDS accepted beats, and done pulses
// for one cycle (the cycle carrying the final write).
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   start             - arms a frame (only honoured while idle)
//   bus (master)      - stream in_valid/in_ready/in_addr/in_data and BRAM port
//   busy              - high while a frame is running
//   done              - one-cycle end-of-frame pulse
//   wr_count          - words written in the current frame
//   drop_count        - out-of-range beats dropped in the current frame
//   oob_err           - sticky out-of-range flag for the current frame
// ---------------------------------------------------------------------------
module bram_write_sa #(
    parameter int unsigned NUM_WORDS = 7056,
    parameter int unsigned MAX_WORDS = 7056,
    parameter bit          ZERO_MSB  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    bram_write_sa_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic [12:0]           wr_count,
    output logic [12:0]           drop_count,
    output logic                  oob_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_ena;
    logic [3:0]  r_wea;
    logic [31:0] r_addra;
    logic [31:0] r_dina;
    logic [12:0] r_wr_count;
    logic [12:0] r_drop_count;
    logic        r_oob_err;

    logic        w_accept;
    logic        w_in_range;
    logic [13:0] w_beats_next;
    logic        w_frame_last;
    logic        w_unused_douta;

    // Results are 3-byte packed unless the top byte is explicitly kept.
    function automatic logic [31:0] pack_dina(input logic [31:0] data);
        if (ZERO_MSB) begin
            return {8'h00, data[23:0]};
        end else begin
            return data;
        end
    endfunction

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_in_range   = ({19'd0, bus.in_addr} < 32'(MAX_WORDS));
    // Both counters already include every earlier accepted beat, so this is
    // the running beat total including the one on the bus right now.
    assign w_beats_next = {1'b0, r_wr_count} + {1'b0, r_drop_count} + 14'd1;
    assign w_frame_last = (w_beats_next == 14'(NUM_WORDS));
    assign w_unused_douta = ^bus.douta;

    // Frame FSM, one-deep write pipeline and frame counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ena        <= 1'b0;
            r_wea        <= 4'b0000;
            r_addra      <= 32'd0;
            r_dina       <= 32'd0;
            r_wr_count   <= 13'd0;
            r_drop_count <= 13'd0;
            r_oob_err    <= 1'b0;
        end else begin
            // A write lasts exactly one cycle unless a new beat re-arms it.
            r_ena  <= 1'b0;
            r_wea  <= 4'b0000;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_wr_count   <= 13'd0;
                        r_drop_count <= 13'd0;
                        r_oob_err    <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_ena      <= 1'b1;
                            r_wea      <= 4'b1111;
                            r_addra    <= {19'd0, bus.in_addr, 2'b00};
                            r_dina     <= pack_dina(bus.in_data);
                            // Counted now so it is visible in the write cycle.
                            r_wr_count <= r_wr_count + 13'd1;
                        end else begin
                            r_drop_count <= r_drop_count + 13'd1;
                            r_oob_err    <= 1'b1;
                        end
                        if (w_frame_last) begin
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.clka     = clk;
    assign bus.rsta     = rst;
    assign bus.ena      = r_ena;
    assign bus.wea      = r_wea;
    assign bus.addra    = r_addra;
    assign bus.dina     = r_dina;
    assign busy         = r_busy;
    assign done         = r_done;
    assign wr_count     = r_wr_count;
    assign drop_count   = r_drop_count;
    assign oob_err      = r_oob_err;

endmodule

// File: tb/tb_bram_write_sa.sv
// Bench for bram_write_sa: a frame-level reference model checks every cycle of
// the default-parameter instance; a vector table exercises a small
// ZERO_MSB=0 instance; hand sequences cover out-of-range, random valid,
// idle beats, start during a frame and asynchronous reset.
module tb_bram_write_sa;
    localparam int NW = 7056;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, busy, done, oob_err;
    logic [12:0] wr_count, drop_count;
    logic        start2, busy2, done2, oob_err2;
    logic [12:0] wr_count2, drop_count2;

    int total = 0;
    int bad   = 0;

    bram_write_sa_if bus();
    bram_write_sa_if bus2();

    always #5 clk = ~clk;

    bram_write_sa u_dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.master),
        .busy(busy), .done(done), .wr_count(wr_count),
        .drop_count(drop_count), .oob_err(oob_err)
    );

    bram_write_sa #(.NUM_WORDS(4), .MAX_WORDS(7056), .ZERO_MSB(1'b0)) u_dut_raw (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2.master),
        .busy(busy2), .done(done2), .wr_count(wr_count2),
        .drop_count(drop_count2), .oob_err(oob_err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    // phase: 0 idle, 1 running, 2 frame-end cycle
    int          m_phase = 0;
    int          m_wr = 0, m_drop = 0;
    bit          m_oob = 1'b0;
    bit          m_ena = 1'b0;
    logic [31:0] m_addra = 32'd0, m_dina = 32'd0;
    int          m_done_pulses = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_wr = 0; m_drop = 0; m_oob = 1'b0;
                m_ena = 1'b0; m_addra = 32'd0; m_dina = 32'd0;
            end else begin
                m_ena = 1'b0;
                if (m_phase == 0) begin
                    if (start) begin
                        m_phase = 1; m_wr = 0; m_drop = 0; m_oob = 1'b0;
                    end
                end else if (m_phase == 2) begin
                    m_phase = 0;
                end else if (bus.in_valid) begin
                    if (int'(bus.in_addr) < NW) begin
                        m_wr++;
                        m_ena   = 1'b1;
                        m_addra = 32'(bus.in_addr) * 32'd4;
                        m_dina  = bus.in_data & 32'h00FF_FFFF;
                    end else begin
                        m_drop++;
                        m_oob = 1'b1;
                    end
                    if (m_wr + m_drop == NW) begin
                        m_phase = 2;
                        m_done_pulses++;
                    end
                end
            end
        end
    end

    // Observed BRAM writes and done pulses of the main instance.
    int n_writes = 0;
    int n_done   = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (bus.ena && bus.wea == 4'b1111) n_writes++;
            if (done) n_done++;
        end
    end

    // Per-cycle comparison of the main instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
            check("busy", 32'(busy), 32'(m_phase == 1));
            check("done", 32'(done), 32'(m_phase == 2));
            check("wr_count", 32'(wr_count), 32'(m_wr));
            check("drop_count", 32'(drop_count), 32'(m_drop));
            check("oob_err", 32'(oob_err), 32'(m_oob));
            check("ena", 32'(bus.ena), 32'(m_ena));
            check("wea", 32'(bus.wea), m_ena ? 32'hF : 32'h0);
            check("addra", bus.addra, m_addra);
            check("dina", bus.dina, m_dina);
            check("rsta", 32'(bus.rsta), 32'(rst));
        end
    end

    // ---------------- vector table for the ZERO_MSB=0 instance ----------------
    typedef struct packed {
        logic        start;
        logic        valid;
        logic [12:0] addr;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_ena;
        logic [31:0] exp_addra;
        logic [31:0] exp_dina;
        logic        exp_done;
        logic [12:0] exp_wr;
        logic [12:0] exp_drop;
        logic        exp_oob;
    } vec_t;

    vec_t vt[10];

    task automatic beat(input logic v, input logic [12:0] a, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic run_frame(input bit with_oob);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (with_oob && i == 100)       beat(1'b1, 13'd7056, $urandom);
            else if (with_oob && i == 5000) beat(1'b1, 13'd8000, $urandom);
            else if (with_oob)              beat(1'b1, 13'($urandom_range(0, NW - 1)), $urandom);
            else                            beat(1'b1, 13'(i), 32'(i) | 32'hAB00_0000);
            @(posedge clk); #1;
        end
        beat(1'b0, 13'd0, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    int done_before, writes_before, budget;

    initial begin
        // rows: start valid addr data | ready ena addra dina done wr drop oob
        vt[0] = '{1'b1, 1'b1, 13'd5,    32'hDEADBEEF, 1'b0, 1'b0, 32'd0,  32'd0,         1'b0, 13'd0, 13'd0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 13'd5,    32'hDEADBEEF, 1'b1, 1'b0, 32'd0,  32'd0,         1'b0, 13'd0, 13'd0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 13'd7056, 32'h11111111, 1'b1, 1'b1, 32'd20, 32'hDEADBEEF,  1'b0, 13'd1, 13'd0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 13'd0,    32'h00000000, 1'b1, 1'b0, 32'd20, 32'hDEADBEEF,  1'b0, 13'd1, 13'd1, 1'b1};
        vt[4] = '{1'b1, 1'b1, 13'd1,    32'h12345678, 1'b1, 1'b0, 32'd20, 32'hDEADBEEF,  1'b0, 13'd1, 13'd1, 1'b1};
        vt[5] = '{1'b0, 1'b1, 13'd1,    32'h9ABCDEF0, 1'b1, 1'b1, 32'd4,  32'h12345678,  1'b0, 13'd2, 13'd1, 1'b1};
        vt[6] = '{1'b0, 1'b1, 13'd2,    32'h55555555, 1'b0, 1'b1, 32'd4,  32'h9ABCDEF0,  1'b1, 13'd3, 13'd1, 1'b1};
        vt[7] = '{1'b0, 1'b0, 13'd0,    32'h00000000, 1'b0, 1'b0, 32'd4,  32'h9ABCDEF0,  1'b0, 13'd3, 13'd1, 1'b1};
        vt[8] = '{1'b1, 1'b0, 13'd0,    32'h00000000, 1'b0, 1'b0, 32'd4,  32'h9ABCDEF0,  1'b0, 13'd3, 13'd1, 1'b1};
        vt[9] = '{1'b0, 1'b0, 13'd0,    32'h00000000, 1'b1, 1'b0, 32'd4,  32'h9ABCDEF0,  1'b0, 13'd0, 13'd0, 1'b0};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        beat(1'b0, 13'd0, 32'd0);
        bus.douta = 32'd0;
        bus2.in_valid = 1'b0; bus2.in_addr = 13'd0; bus2.in_data = 32'd0; bus2.douta = 32'd0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Table: ZERO_MSB=0, passthrough data, drop, duplicate address, done.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start2 = vt[i].start;
            bus2.in_valid = vt[i].valid; bus2.in_addr = vt[i].addr; bus2.in_data = vt[i].data;
            @(negedge clk);
            check($sformatf("t%0d_ready", i), 32'(bus2.in_ready), 32'(vt[i].exp_ready));
            check($sformatf("t%0d_busy", i), 32'(busy2), 32'(vt[i].exp_ready));
            check($sformatf("t%0d_ena", i), 32'(bus2.ena), 32'(vt[i].exp_ena));
            check($sformatf("t%0d_wea", i), 32'(bus2.wea), vt[i].exp_ena ? 32'hF : 32'h0);
            check($sformatf("t%0d_addra", i), bus2.addra, vt[i].exp_addra);
            check($sformatf("t%0d_dina", i), bus2.dina, vt[i].exp_dina);
            check($sformatf("t%0d_done", i), 32'(done2), 32'(vt[i].exp_done));
            check($sformatf("t%0d_wr", i), 32'(wr_count2), 32'(vt[i].exp_wr));
            check($sformatf("t%0d_drop", i), 32'(drop_count2), 32'(vt[i].exp_drop));
            check($sformatf("t%0d_oob", i), 32'(oob_err2), 32'(vt[i].exp_oob));
        end
        @(posedge clk); #1;
        start2 = 1'b0; bus2.in_valid = 1'b0;

        // Frame 1: addresses 0..NW-1 in order.
        done_before = n_done;
        run_frame(1'b0);
        check("f1_wr", 32'(wr_count), 32'(NW));
        check("f1_drop", 32'(drop_count), 32'd0);
        check("f1_oob", 32'(oob_err), 32'd0);
        check("f1_done_pulses", 32'(n_done - done_before), 32'd1);

        // Frame 2: two out-of-range beats inside the frame.
        done_before = n_done;
        run_frame(1'b1);
        check("f2_wr", 32'(wr_count), 32'(NW - 2));
        check("f2_drop", 32'(drop_count), 32'd2);
        check("f2_oob", 32'(oob_err), 32'd1);
        check("f2_done_pulses", 32'(n_done - done_before), 32'd1);

        // Beats offered while idle must be ignored.
        writes_before = n_writes;
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 13'(i), 32'hCAFE_0000 + 32'(i));
            @(posedge clk); #1;
        end
        check("idle_no_writes", 32'(n_writes - writes_before), 32'd0);
        check("idle_ready", 32'(bus.in_ready), 32'd0);

        // Frame 3: random valid, occasional out-of-range, start mid-frame.
        done_before = n_done;
        writes_before = n_writes;
        beat(1'b0, 13'd0, 32'd0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        budget = 0;
        while (m_done_pulses == done_before + 0 && n_done == done_before && budget < 40000) begin
            if ($urandom_range(0, 15) == 0)
                beat(1'($urandom_range(0, 1)), 13'(7056 + $urandom_range(0, 1000)), $urandom);
            else
                beat(1'($urandom_range(0, 1)), 13'($urandom_range(0, NW - 1)), $urandom);
            start = (budget == 50);
            @(posedge clk); #1;
            if (budget == 50) begin
                check("start_in_run_busy", 32'(busy), 32'd1);
                check("start_in_run_kept", 32'(wr_count + drop_count), 32'(m_wr + m_drop));
            end
            budget++;
        end
        start = 1'b0;
        beat(1'b0, 13'd0, 32'd0);
        if (budget >= 40000) begin
            bad++;
            $display("FAIL f3_timeout: frame end not reached within %0d cycles", budget);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("f3_total", 32'(wr_count + drop_count), 32'(NW));
        check("f3_writes_seen", 32'(n_writes - writes_before), 32'(m_wr));
        check("f3_done_pulses", 32'(n_done - done_before), 32'd1);

        // Asynchronous reset with a write pending.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 13'(i + 100), 32'h0012_3400 + 32'(i));
            @(posedge clk); #1;
        end
        beat(1'b0, 13'd0, 32'd0);
        check("pre_rst_ena", 32'(bus.ena), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_ena", 32'(bus.ena), 32'd0);
        check("rst_wea", 32'(bus.wea), 32'd0);
        check("rst_addra", bus.addra, 32'd0);
        check("rst_dina", bus.dina, 32'd0);
        check("rst_wr", 32'(wr_count), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #3 rst = 1'b0;

        // Clean frame after reset.
        done_before = n_done;
        run_frame(1'b0);
        check("f4_wr", 32'(wr_count), 32'(NW));
        check("f4_oob", 32'(oob_err), 32'd0);
        check("f4_done_pulses", 32'(n_done - done_before), 32'd1);
        check("all_done_pulses", 32'(n_done), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
